// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, encodings and buffer entry type for the fetch stage
// Contents: XLEN, NOP encoding, PC increment, fetch_entry_t {instr, pc}, align_pc helper.
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect and decode handshake bundle of the fetch stage
// master: fetch side (drives imem_req/imem_addr, id_valid/id_instr/id_pc)
// slave:  environment side (drives imem_rdata, redirect_valid/redirect_pc, id_ready)
interface fetch_stage_if;
  import fetch_stage_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: circular instruction buffer with synchronous push/pop, flush and occupancy count
// Ports: clk, reset (async, active-high), flush, push/wdata, pop, head (oldest entry), count.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign head = mem[rd];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= wdata;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, synchronous imem request, buffered hand-off to decode with redirect flush
// Ports: clk, reset (async, active-high), bus (fetch_stage_if.master).
// Optional FETCH_PERF_EN adds perf_fetched (accepted pops) and perf_stall (id_valid && !id_ready cycles).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall,
`endif
  fetch_stage_if.master   bus
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  logic [XLEN-1:0] pc, inflight_pc;
  logic inflight, pop, push;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign pop = bus.id_valid && bus.id_ready;
  // the response arriving in a redirect cycle belongs to the old path
  assign push = inflight && !bus.redirect_valid;
  // reserve a slot for every word already requested so the buffer never overflows
  assign bus.imem_req = !reset && !bus.redirect_valid &&
                        (int'(count) + int'(inflight) - int'(pop) < BUF_DEPTH);
  assign bus.imem_addr = pc;
  assign bus.id_valid = count != '0;
  assign bus.id_instr = head.instr;
  assign bus.id_pc = head.pc;
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(bus.redirect_valid),
    .push(push),
    .wdata('{instr: bus.imem_rdata, pc: inflight_pc}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= bus.imem_req;
      inflight_pc <= pc;
      pc <= bus.redirect_valid ? align_pc(bus.redirect_pc) : bus.imem_req ? pc + PC_INC : pc;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + XLEN'(pop);
      perf_stall <= perf_stall + XLEN'(bus.id_valid && !bus.id_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized self-checking bench for fetch_stage against a queue model
module tb_fetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] RP = 32'h0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [31:0] mem [64];
  fetch_stage_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  fetch_stage #(.RESET_PC(RP), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem[bus.imem_addr[7:2]] : bus.imem_rdata;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // model: queue of buffered PCs, one outstanding request, plain PC arithmetic
  logic [31:0] q [$];
  int infl;
  logic [31:0] infl_pc, mpc, m_fetched, m_stall;
  int cyc, first_valid;
  logic [31:0] acc_pc [$];
  logic [31:0] acc_ins [$];
  int acc_cyc [$];
  logic ev, mpop, er;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_id_valid", 32'(bus.id_valid), 0);
      chk("rst_imem_req", 32'(bus.imem_req), 0);
      chk("rst_id_instr", bus.id_instr, 0);
      chk("rst_id_pc", bus.id_pc, 0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_fetched", perf_fetched, 0);
      chk("rst_perf_stall", perf_stall, 0);
`endif
      q.delete();
      infl = 0;
      mpc = RP;
      cyc = 0;
      first_valid = -1;
      acc_pc.delete();
      acc_ins.delete();
      acc_cyc.delete();
      m_fetched = 0;
      m_stall = 0;
    end else begin
      ev = q.size() > 0;
      mpop = ev && bus.id_ready;
      er = !bus.redirect_valid && (q.size() + infl - int'(mpop) < DEPTH);
      chk("id_valid", 32'(bus.id_valid), 32'(ev));
      if (ev) begin
        chk("id_pc", bus.id_pc, q[0]);
        chk("id_instr", bus.id_instr, mem[q[0][7:2]]);
      end
      chk("imem_req", 32'(bus.imem_req), 32'(er));
      if (er) chk("imem_addr", bus.imem_addr, mpc);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
`endif
      if (bus.id_valid && bus.id_ready) begin
        acc_pc.push_back(bus.id_pc);
        acc_ins.push_back(bus.id_instr);
        acc_cyc.push_back(cyc);
      end
      if (bus.id_valid && first_valid < 0) first_valid = cyc;
      if (mpop) begin
        m_fetched++;
        void'(q.pop_front());
      end
      if (ev && !bus.id_ready) m_stall++;
      if (bus.redirect_valid) begin
        q.delete();
        infl = 0;
        mpc = bus.redirect_pc & ~32'h3;
      end else begin
        if (infl != 0) q.push_back(infl_pc);
        infl = int'(er);
        infl_pc = mpc;
        if (er) mpc = mpc + 32'd4;
      end
      cyc++;
    end
  end

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.id_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rel_rst(input logic rdy);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.id_ready = rdy;
    bus.redirect_valid = 1'b0;
  endtask

  int nb;
  logic seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00A00093;
    mem[1] = 32'h00500113;
    mem[2] = 32'h002081B3;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);

    // basic stream with decode always ready
    rel_rst(1'b1);
    repeat (7) step(1'b1, 1'b0, 0);
    chk("a_first_valid_cyc", first_valid, 2);
    chk("a_acc_size", 32'(acc_pc.size() >= 3), 1);
    for (int i = 0; i < 3; i++) begin
      chk("a_pc", acc_pc[i], 32'(4 * i));
      chk("a_cyc", acc_cyc[i], 32'(2 + i));
    end
    chk("a_ins0", acc_ins[0], 32'h00A00093);
    chk("a_ins1", acc_ins[1], 32'h00500113);
    chk("a_ins2", acc_ins[2], 32'h002081B3);

    // stall with full buffer, then drain
    do_reset();
    rel_rst(1'b0);
    repeat (6) step(1'b0, 1'b0, 0);
    #2;
    chk("b_valid", 32'(bus.id_valid), 1);
    chk("b_req", 32'(bus.imem_req), 0);
    chk("b_instr", bus.id_instr, 32'h00A00093);
    chk("b_pc", bus.id_pc, 0);
    repeat (10) step(1'b1, 1'b0, 0);
    chk("b_acc_size", 32'(acc_pc.size() >= 8), 1);
    for (int i = 0; i < 8; i++) chk("b_seq", acc_pc[i], 32'(4 * i));

    // redirect coinciding with a pop, in-flight PC 8 killed
    do_reset();
    rel_rst(1'b0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b0, 0);
    #2;
    chk("c_valid_after_redirect", 32'(bus.id_valid), 0);
    repeat (4) step(1'b1, 1'b0, 0);
    chk("c_pc0", acc_pc[0], 32'h0);
    chk("c_pc1", acc_pc[1], 32'h4);
    chk("c_pc2", acc_pc[2], 32'h40);
    chk("c_pc3", acc_pc[3], 32'h44);
    chk("c_cyc2", acc_cyc[2], 6);
    seen = 1'b0;
    foreach (acc_pc[i]) if (acc_pc[i] == 32'h8) seen = 1'b1;
    chk("c_no_pc8", 32'(seen), 0);

    // back-to-back redirects, misaligned target, address wrap
    do_reset();
    rel_rst(1'b1);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h43);
    nb = acc_pc.size();
    step(1'b1, 1'b0, 0);
    #2;
    chk("d_req", 32'(bus.imem_req), 1);
    chk("d_addr", bus.imem_addr, 32'h40);
    repeat (5) step(1'b1, 1'b0, 0);
    chk("d_first", acc_pc[nb], 32'h40);
    chk("d_second", acc_pc[nb + 1], 32'h44);
    seen = 1'b0;
    foreach (acc_pc[i]) if (acc_pc[i] == 32'h100) seen = 1'b1;
    chk("d_no_0x100", 32'(seen), 0);
    step(1'b1, 1'b1, 32'hFFFF_FFF9);
    step(1'b1, 1'b0, 0);
    nb = acc_pc.size();
    repeat (6) step(1'b1, 1'b0, 0);
    chk("d_wrap0", acc_pc[nb], 32'hFFFF_FFF8);
    chk("d_wrap1", acc_pc[nb + 1], 32'hFFFF_FFFC);
    chk("d_wrap2", acc_pc[nb + 2], 32'h0);

    // asynchronous reset mid-stream
    do_reset();
    rel_rst(1'b1);
    repeat (5) step(1'b1, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("e_async_valid", 32'(bus.id_valid), 0);
    chk("e_async_req", 32'(bus.imem_req), 0);
    rel_rst(1'b1);
    repeat (4) step(1'b1, 1'b0, 0);
    chk("e_refetch_pc", acc_pc[0], RP);
    chk("e_refetch_cyc", acc_cyc[0], 2);

    // randomized traffic
    do_reset();
    rel_rst(1'b1);
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 10) < 7, ($urandom % 20) == 0,
           ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : $urandom);
      if ($urandom % 200 == 0) begin
        #2;
        reset = 1'b1;
        rel_rst(1'b1);
      end
    end

`ifdef FETCH_PERF_EN
    do_reset();
    rel_rst(1'b1);
    repeat (6) step(1'b1, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 32'h200);
    repeat (2) step(1'b0, 1'b0, 0);
    #2;
    chk("p_fetched", perf_fetched, 10);
    chk("p_stall", perf_stall, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
